game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 19 +
 rtl/game_flow_ctrl_if.sv | 33 +++
 rtl/game_flow_ctrl_popcount.sv | 16 +
 rtl/game_flow_ctrl.sv | 144 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared state codes for the game flow controller, compositor and music block.
package game_pkg;

  localparam logic [3:0] ST_START = 4'd0;
  localparam logic [3:0] ST_PAUSE = 4'd14;
  localparam logic [3:0] ST_FAIL  = 4'd15;

  typedef enum logic [1:0] {
    S_START,
    S_PLAY,
    S_PAUSE,
    S_FAIL
  } flow_state_t;

  function automatic logic is_play(input logic [3:0] code);
    return (code != ST_START) && (code < ST_PAUSE);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Input-decode and renderer-facing signals of the game flow controller.
interface game_flow_ctrl_if #(
  parameter int N_LANES  = 3,
  parameter int LIFE_MAX = 10,
  parameter int MONEY_W  = 7
);
  localparam int LIFE_W = $clog2(LIFE_MAX + 1);

  logic [3:0]          level_req;
  logic                level_req_vld;
  logic                ticket;
  logic                pause_key;
  logic                return_key;
  logic                gameend;
  logic [N_LANES-1:0]  hit;
  logic [N_LANES-1:0]  damage;
  logic [3:0]          state_code;
  logic                play_active;
  logic [LIFE_W-1:0]   life_cnt;
  logic [LIFE_MAX-1:0] life_bar;
  logic [MONEY_W-1:0]  money;
  logic                fail;

  modport master (
    output level_req, level_req_vld, ticket, pause_key, return_key, gameend, hit, damage,
    input  state_code, play_active, life_cnt, life_bar, money, fail
  );

  modport slave (
    input  level_req, level_req_vld, ticket, pause_key, return_key, gameend, hit, damage,
    output state_code, play_active, life_cnt, life_bar, money, fail
  );
endinterface

// File: rtl/game_flow_ctrl_popcount.sv
// Combinational population count of a W-bit vector.
module popcount_n #(
  parameter int W = 3
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   cnt
);
  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + CW'(bits[i]);
    end
  end
endmodule

// File: rtl/game_flow_ctrl.sv
// Multi-level game flow FSM: levels, lane hits/damage, life/money, tickets, pause, failure.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int N_LANES      = 3,
  parameter int N_LEVELS     = 3,
  parameter int LIFE_MAX     = 10,
  parameter int LIFE_INIT    = 8,
  parameter int MONEY_W      = 7,
  parameter int HIT_REWARD   = 1,
  parameter int TICKET_COST  = 10,
  parameter int FAIL_TIMEOUT = 0
) (
  input logic             clk,
  input logic             rst,
  game_flow_ctrl_if.slave bus
);
  localparam int LIFE_W = $clog2(LIFE_MAX + 1);
  localparam int PC_W   = $clog2(N_LANES + 1);
  localparam int TMR_W  = (FAIL_TIMEOUT > 1) ? $clog2(FAIL_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'((FAIL_TIMEOUT > 0) ? FAIL_TIMEOUT - 1 : 0);
  localparam logic [MONEY_W-1:0] MONEY_MAX = '1;

  flow_state_t         state, state_n;
  logic [3:0]          level, level_n, saved_level, saved_level_n;
  logic [LIFE_W-1:0]   life, life_n, start_life, start_life_n, life_dec;
  logic [MONEY_W-1:0]  money, money_n, money_inc;
  logic [TMR_W-1:0]    tmr, tmr_n;
  logic                fail_n;
  logic [3:0]          code_n;
  logic [LIFE_MAX-1:0] bar_n;
  logic [PC_W-1:0]     hit_cnt, dmg_cnt;
  logic [31:0]         money_sum;
  logic                level_ok, ticket_ok;

  popcount_n #(.W(N_LANES)) u_hit_cnt (.bits(bus.hit),    .cnt(hit_cnt));
  popcount_n #(.W(N_LANES)) u_dmg_cnt (.bits(bus.damage), .cnt(dmg_cnt));

  assign money_sum = 32'(money) + 32'(hit_cnt) * 32'(HIT_REWARD);
  assign money_inc = (money_sum > 32'(MONEY_MAX)) ? MONEY_MAX : money_sum[MONEY_W-1:0];
  assign life_dec  = (32'(life) > 32'(dmg_cnt)) ? life - LIFE_W'(dmg_cnt) : '0;
  assign level_ok  = bus.level_req_vld && (bus.level_req != 4'd0)
                     && (32'(bus.level_req) <= 32'(N_LEVELS));
  assign ticket_ok = bus.ticket && (32'(money) >= 32'(TICKET_COST))
                     && (32'(start_life) < 32'(LIFE_MAX));

  always_comb begin
    state_n       = state;
    level_n       = level;
    saved_level_n = saved_level;
    life_n        = life;
    start_life_n  = start_life;
    money_n       = money;
    tmr_n         = '0;
    fail_n        = 1'b0;
    case (state)
      S_START: begin
        if (level_ok) begin
          state_n      = S_PLAY;
          level_n      = bus.level_req;
          life_n       = start_life;
          start_life_n = LIFE_W'(LIFE_INIT);
        end else if (ticket_ok) begin
          money_n      = money - MONEY_W'(TICKET_COST);
          start_life_n = start_life + LIFE_W'(1);
        end
      end
      S_PLAY: begin
        // Lane effects land even on the cycle that also ends or pauses the game.
        life_n  = life_dec;
        money_n = money_inc;
        if (bus.gameend) begin
          state_n = S_START;
        end else if (life_dec == '0) begin
          state_n = S_FAIL;
          fail_n  = 1'b1;
        end else if (bus.pause_key) begin
          state_n       = S_PAUSE;
          saved_level_n = level;
        end
      end
      S_PAUSE: begin
        if (bus.return_key) begin
          state_n = S_START;
        end else if (bus.pause_key) begin
          state_n = S_PLAY;
          level_n = saved_level;
        end
      end
      S_FAIL: begin
        if (bus.return_key || ((FAIL_TIMEOUT > 0) && (tmr == TMR_LAST))) begin
          state_n = S_START;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      default: state_n = S_START;
    endcase

    case (state_n)
      S_PLAY:  code_n = level_n;
      S_PAUSE: code_n = ST_PAUSE;
      S_FAIL:  code_n = ST_FAIL;
      default: code_n = ST_START;
    endcase

    bar_n = '0;
    for (int unsigned i = 0; i < LIFE_MAX; i++) begin
      bar_n[i] = (32'(life_n) > i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_START;
      level           <= '0;
      saved_level     <= '0;
      life            <= '0;
      start_life      <= LIFE_W'(LIFE_INIT);
      money           <= '0;
      tmr             <= '0;
      bus.state_code  <= ST_START;
      bus.play_active <= 1'b0;
      bus.life_bar    <= '0;
      bus.fail        <= 1'b0;
    end else begin
      state           <= state_n;
      level           <= level_n;
      saved_level     <= saved_level_n;
      life            <= life_n;
      start_life      <= start_life_n;
      money           <= money_n;
      tmr             <= tmr_n;
      bus.state_code  <= code_n;
      bus.play_active <= is_play(code_n);
      bus.life_bar    <= bar_n;
      bus.fail        <= fail_n;
    end
  end

  assign bus.life_cnt = life;
  assign bus.money    = money;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl: two DUTs (auto-return off / 16 cycles) against a rule-level model.
module tb_game_flow_ctrl;
  localparam int NL = 3, LMAX = 10, LINIT = 8, MMAX = 127, COST = 10, TO1 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  game_flow_ctrl_if #(.N_LANES(3), .LIFE_MAX(LMAX), .MONEY_W(7)) if0 ();
  game_flow_ctrl_if #(.N_LANES(3), .LIFE_MAX(LMAX), .MONEY_W(7)) if1 ();

  game_flow_ctrl #(.FAIL_TIMEOUT(0))   dut0 (.clk(clk), .rst(rst), .bus(if0));
  game_flow_ctrl #(.FAIL_TIMEOUT(TO1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    int code;
    int life;
    int start_life;
    int money;
    int saved;
    int timer;
    int fail;
  } mdl_t;

  mdl_t m0, m1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t step(input mdl_t m, input int to, input int r, input int rq,
                                input int v, input int tk, input int pk, input int rk,
                                input int ge, input int h, input int d);
    mdl_t n = m;
    n.fail = 0;
    if (r != 0) begin
      n.code = 0; n.life = 0; n.start_life = LINIT; n.money = 0;
      n.saved = 0; n.timer = 0;
      return n;
    end
    if (m.code == 0) begin
      if (v != 0 && rq >= 1 && rq <= NL) begin
        n.code = rq; n.life = m.start_life; n.start_life = LINIT;
      end else if (tk != 0 && m.money >= COST && m.start_life < LMAX) begin
        n.money = m.money - COST; n.start_life = m.start_life + 1;
      end
    end else if (m.code == 14) begin
      if (rk != 0) n.code = 0;
      else if (pk != 0) n.code = m.saved;
    end else if (m.code == 15) begin
      if (rk != 0 || (to > 0 && m.timer == to - 1)) begin
        n.code = 0; n.timer = 0;
      end else n.timer = m.timer + 1;
    end else begin
      n.life  = (m.life > d) ? m.life - d : 0;
      n.money = (m.money + h > MMAX) ? MMAX : m.money + h;
      if (ge != 0) n.code = 0;
      else if (n.life == 0) begin
        n.code = 15; n.fail = 1; n.timer = 0;
      end else if (pk != 0) begin
        n.saved = m.code; n.code = 14;
      end
    end
    return n;
  endfunction

  task automatic compare_dut(input string p, input mdl_t m, input int code, input int pa,
                             input int life, input int bar, input int money, input int fail);
    check({p, ".state_code"},  code,  m.code);
    check({p, ".play_active"}, pa,    (m.code >= 1 && m.code <= NL) ? 1 : 0);
    check({p, ".life_cnt"},    life,  m.life);
    check({p, ".life_bar"},    bar,   (1 << m.life) - 1);
    check({p, ".money"},       money, m.money);
    check({p, ".fail"},        fail,  m.fail);
  endtask

  task automatic cycle(input bit r, input logic [3:0] rq, input bit v, input bit tk,
                       input bit pk, input bit rk, input bit ge,
                       input logic [2:0] h, input logic [2:0] d);
    rst = r;
    if0.level_req = rq; if0.level_req_vld = v; if0.ticket = tk; if0.pause_key = pk;
    if0.return_key = rk; if0.gameend = ge; if0.hit = h; if0.damage = d;
    if1.level_req = rq; if1.level_req_vld = v; if1.ticket = tk; if1.pause_key = pk;
    if1.return_key = rk; if1.gameend = ge; if1.hit = h; if1.damage = d;
    @(posedge clk);
    m0 = step(m0, 0,   int'(r), int'(rq), int'(v), int'(tk), int'(pk), int'(rk), int'(ge),
              $countones(h), $countones(d));
    m1 = step(m1, TO1, int'(r), int'(rq), int'(v), int'(tk), int'(pk), int'(rk), int'(ge),
              $countones(h), $countones(d));
    #1;
    compare_dut("d0", m0, int'(if0.state_code), int'(if0.play_active), int'(if0.life_cnt),
                int'(if0.life_bar), int'(if0.money), int'(if0.fail));
    compare_dut("d1", m1, int'(if1.state_code), int'(if1.play_active), int'(if1.life_cnt),
                int'(if1.life_bar), int'(if1.money), int'(if1.fail));
  endtask

  task automatic idle();
    cycle(0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
  endtask

  initial begin
    m0 = '{code: 0, life: 0, start_life: LINIT, money: 0, saved: 0, timer: 0, fail: 0};
    m1 = m0;

    cycle(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cycle(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    check("reset_code", int'(if0.state_code), 0);
    check("reset_money", int'(if0.money), 0);

    cycle(0, 4'd0, 0, 1, 0, 0, 0, 3'b000, 3'b000);
    check("ticket_broke", int'(if0.money), 0);
    cycle(0, 4'd2, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    check("enter_l2_code", int'(if0.state_code), 2);
    check("enter_l2_life", int'(if0.life_cnt), 8);
    check("enter_l2_bar", int'(if0.life_bar), 'h0FF);

    for (int i = 0; i < 4; i++) cycle(0, 4'd0, 0, 0, 0, 0, 0, 3'b111, 3'b000);
    check("hits_money", int'(if0.money), 12);
    cycle(0, 4'd0, 0, 0, 1, 0, 0, 3'b000, 3'b000);
    check("pause_code", int'(if0.state_code), 14);
    cycle(0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 3'b111);
    check("pause_no_damage", int'(if0.life_cnt), 8);
    cycle(0, 4'd0, 0, 0, 1, 1, 0, 3'b000, 3'b000);
    check("return_wins", int'(if0.state_code), 0);
    check("return_no_fail", int'(if0.fail), 0);
    cycle(0, 4'd0, 0, 1, 0, 0, 0, 3'b000, 3'b000);
    check("ticket_money", int'(if0.money), 2);
    cycle(0, 4'd1, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    check("ticket_life", int'(if0.life_cnt), 9);

    for (int i = 0; i < 4; i++) cycle(0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 3'b101);
    check("life_one", int'(if0.life_cnt), 1);
    cycle(0, 4'd0, 0, 0, 0, 0, 1, 3'b000, 3'b001);
    check("gameend_wins_code", int'(if0.state_code), 0);
    check("gameend_wins_fail", int'(if0.fail), 0);

    cycle(0, 4'd9, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    check("bad_level", int'(if0.state_code), 0);
    cycle(0, 4'd1, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) cycle(0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 3'b101);
    check("fail_code", int'(if0.state_code), 15);
    check("fail_pulse", int'(if0.fail), 1);
    for (int i = 0; i < 15; i++) idle();
    check("fail_pulse_once", int'(if0.fail), 0);
    check("timeout_not_yet", int'(if1.state_code), 15);
    idle();
    check("timeout_start", int'(if1.state_code), 0);
    check("no_timeout_hold", int'(if0.state_code), 15);
    cycle(0, 4'd0, 0, 0, 0, 1, 0, 3'b000, 3'b000);
    check("fail_return", int'(if0.state_code), 0);

    for (int i = 0; i < 4000; i++) begin
      logic [3:0] rq;
      logic [2:0] h, d;
      rq = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      h  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      d  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      cycle($urandom_range(0, 299) == 0, rq, $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0, h, d);
    end

    cycle(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cycle(0, 4'd3, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 45; i++) cycle(0, 4'd0, 0, 0, 0, 0, 0, 3'b111, 3'b000);
    check("money_saturate", int'(if0.money), 127);
    cycle(1, 4'd2, 1, 1, 1, 0, 0, 3'b111, 3'b111);
    check("rst_mid_code", int'(if0.state_code), 0);
    check("rst_mid_money", int'(if0.money), 0);
    check("rst_mid_life", int'(if0.life_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
